// File: rtl/cam_match_encoder.sv
// cam_match_encoder: serializes a CAM match bitmap into lowest-first address beats
// with a miss beat for an empty bitmap and a per-lookup hit count.
module cam_match_encoder #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic [2**ADDR_WIDTH-1:0] s_match,
    input  logic [DATA_WIDTH-1:0]    s_key,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [ADDR_WIDTH-1:0]    m_addr,
    output logic                     m_hit,
    output logic                     m_last,
    output logic [DATA_WIDTH-1:0]    m_key,
    output logic [ADDR_WIDTH:0]      m_count
);
    localparam int N = 2**ADDR_WIDTH;

    typedef enum logic [1:0] {IDLE, SCAN, MISS} state_t;

    state_t                state, state_nxt;
    logic [N-1:0]          pending;
    logic [DATA_WIDTH-1:0] key_r;
    logic [ADDR_WIDTH:0]   count_r, pop;
    logic [ADDR_WIDTH-1:0] low;
    logic                  one_left;

    always_comb begin
        low = '0;
        pop = '0;
        for (int i = N - 1; i >= 0; i--)
            if (pending[i]) low = ADDR_WIDTH'(i);
        for (int i = 0; i < N; i++)
            pop = pop + (ADDR_WIDTH + 1)'(s_match[i]);
    end

    // pending & (pending-1) drops the lowest set bit: empty means exactly one was left
    assign one_left = (pending & (pending - 1'b1)) == '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending <= '0;
            key_r   <= '0;
            count_r <= '0;
        end else if (state == IDLE && s_valid) begin
            pending <= s_match;
            key_r   <= s_key;
            count_r <= pop;
        end else if (state == SCAN && m_ready) begin
            pending <= pending & (pending - 1'b1);
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = s_valid ? (|s_match ? SCAN : MISS) : IDLE;
            SCAN:    state_nxt = (m_ready && one_left) ? IDLE : SCAN;
            MISS:    state_nxt = m_ready ? IDLE : MISS;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        s_ready = state == IDLE;
        m_valid = state != IDLE;
        m_hit   = state == SCAN;
        m_addr  = state == SCAN ? low : '0;
        m_last  = state == SCAN ? one_left : state == MISS;
        m_key   = key_r;
        m_count = count_r;
    end
endmodule

// File: tb/tb_cam_match_encoder.sv
// tb_cam_match_encoder: directed checks of beat order, miss, backpressure,
// full bitmap, busy-input rejection and asynchronous reset.
module tb_cam_match_encoder;
    logic        clk = 0, rst = 1;
    logic        s_valid = 0, s_ready, m_valid, m_ready = 1, m_hit, m_last;
    logic [15:0] s_match = '0;
    logic [3:0]  s_key = '0, m_addr, m_key;
    logic [4:0]  m_count;
    int          passed = 0, total = 0;

    cam_match_encoder #(.ADDR_WIDTH(4), .DATA_WIDTH(4)) dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready),
        .s_match(s_match), .s_key(s_key), .m_valid(m_valid), .m_ready(m_ready),
        .m_addr(m_addr), .m_hit(m_hit), .m_last(m_last), .m_key(m_key), .m_count(m_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic beat(input string tag, input int addr, input bit hit, input bit last,
                        input int cnt, input int key);
        chk({tag, " valid"}, 32'(m_valid), 1);
        chk({tag, " s_ready"}, 32'(s_ready), 0);
        chk({tag, " addr"}, 32'(m_addr), 32'(addr));
        chk({tag, " hit"}, 32'(m_hit), 32'(hit));
        chk({tag, " last"}, 32'(m_last), 32'(last));
        chk({tag, " count"}, 32'(m_count), 32'(cnt));
        chk({tag, " key"}, 32'(m_key), 32'(key));
    endtask

    task automatic idle(input string tag);
        chk({tag, " idle valid"}, 32'(m_valid), 0);
        chk({tag, " idle s_ready"}, 32'(s_ready), 1);
    endtask

    task automatic start(input logic [15:0] match, input logic [3:0] key);
        chk("start s_ready", 32'(s_ready), 1);
        s_valid = 1; s_match = match; s_key = key;
        @(negedge clk);
        s_valid = 0; s_match = '0; s_key = '0;
    endtask

    initial begin
        #1;
        chk("rst s_ready", 32'(s_ready), 1);
        chk("rst m_valid", 32'(m_valid), 0);
        chk("rst m_key", 32'(m_key), 0);
        chk("rst m_count", 32'(m_count), 0);
        @(negedge clk); @(negedge clk);
        rst = 0;
        @(negedge clk);

        // multi-hit 16'h8421 -> 0,5,10,15
        start(16'h8421, 4'hA);
        beat("multi0", 0, 1, 0, 4, 'hA);  @(negedge clk);
        beat("multi5", 5, 1, 0, 4, 'hA);  @(negedge clk);
        beat("multi10", 10, 1, 0, 4, 'hA); @(negedge clk);
        beat("multi15", 15, 1, 1, 4, 'hA); @(negedge clk);
        idle("multi");
        chk("multi hold key", 32'(m_key), 'hA);
        chk("multi hold count", 32'(m_count), 4);
        chk("multi idle last", 32'(m_last), 0);

        start(16'h0000, 4'h3);
        beat("miss", 0, 0, 1, 0, 3); @(negedge clk);
        idle("miss");

        m_ready = 0;
        start(16'h0006, 4'h1);
        for (int i = 0; i < 3; i++) begin
            beat($sformatf("bp stall%0d", i), 1, 1, 0, 2, 1);
            @(negedge clk);
        end
        m_ready = 1;
        beat("bp beat1", 1, 1, 0, 2, 1); @(negedge clk);
        beat("bp beat2", 2, 1, 1, 2, 1); @(negedge clk);
        idle("bp");

        start(16'hFFFF, 4'h5);
        for (int i = 0; i < 16; i++) begin
            beat($sformatf("full%0d", i), i, 1, i == 15, 16, 5);
            @(negedge clk);
        end
        idle("full");

        start(16'h0101, 4'h6);
        beat("busy0", 0, 1, 0, 2, 6);
        s_valid = 1; s_match = 16'h0010; s_key = 4'h9;
        @(negedge clk);
        beat("busy8", 8, 1, 1, 2, 6);
        @(negedge clk);
        idle("busy");
        @(negedge clk);
        s_valid = 0; s_match = '0; s_key = '0;
        beat("busy new", 4, 1, 1, 1, 9);
        @(negedge clk);
        idle("busy new");

        start(16'h00F0, 4'h7);
        beat("rst4", 4, 1, 0, 4, 7); @(negedge clk);
        beat("rst5", 5, 1, 0, 4, 7);
        #2 rst = 1;
        #1;
        chk("async m_valid", 32'(m_valid), 0);
        chk("async s_ready", 32'(s_ready), 1);
        chk("async m_key", 32'(m_key), 0);
        chk("async m_count", 32'(m_count), 0);
        chk("async m_addr", 32'(m_addr), 0);
        @(negedge clk);
        rst = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            idle($sformatf("post rst%0d", i));
            chk("post rst key", 32'(m_key), 0);
            chk("post rst count", 32'(m_count), 0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
